// File: rtl/cla_pkg.sv
// Shared constants and helpers for the two-level carry-lookahead adder.
// Latency: none (declarations only).
// Backpressure: none.
package cla_pkg;

  // Bits per first-level lookahead group.
  localparam int CLA_GROUP_W          = 4;
  // Groups (or P/G pairs) combined by one second-level unit.
  localparam int CLA_GROUPS_PER_LEVEL = 4;
  // Bits covered by one second-level unit.
  localparam int CLA_UNIT_W           = CLA_GROUP_W * CLA_GROUPS_PER_LEVEL;

  // The only operand widths the adder supports: one or two 16-bit halves.
  localparam int CLA_LEGAL_W_LO = 16;
  localparam int CLA_LEGAL_W_HI = 32;

  function automatic bit cla_width_ok(input int w);
    return (w == CLA_LEGAL_W_LO) || (w == CLA_LEGAL_W_HI);
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit lookahead slice: sum bits plus group propagate/generate.
// Latency: combinational.
// Backpressure: none.
module cla_4bit
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] s,
  output logic                   p,
  output logic                   g
);

  logic [CLA_GROUP_W-1:0] pb;
  logic [CLA_GROUP_W-1:0] gb;
  logic [CLA_GROUP_W-1:0] c;

  assign pb = a ^ b;
  assign gb = a & b;

  // Every carry is a flat sum of products from cin, so no carry waits on another.
  always_comb begin
    c[0] = cin;
    c[1] = gb[0] | (pb[0] & cin);
    c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
         | (pb[2] & pb[1] & pb[0] & cin);
  end

  assign s = pb ^ c;

  assign p = &pb;
  assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
           | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/cla_lookahead_unit.sv
// Second-level lookahead: four group P/G pairs to inter-group carries and cout.
// Latency: combinational.
// Backpressure: none.
module cla_lookahead_unit
  import cla_pkg::*;
(
  input  logic [CLA_GROUPS_PER_LEVEL-1:0] p,
  input  logic [CLA_GROUPS_PER_LEVEL-1:0] g,
  input  logic                            cin,
  output logic [3:1]                      c,
  output logic                            blk_p,
  output logic                            blk_g,
  output logic                            cout
);

  // Same flattened equations as inside a group, one level up on group P/G.
  always_comb begin
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
  end

  assign blk_p = &p;
  assign blk_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign cout  = blk_g | (blk_p & cin);

endmodule

// File: rtl/carry_look_ahead_adder_32bit.sv
// Registered two-level carry-lookahead adder: {cout,sum} = A + B + cin.
// Latency: 1 cycle, one new operand pair accepted every cycle.
// Backpressure: none; no handshake, results are overwritten each edge.
module carry_look_ahead_adder_32bit
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP  = WIDTH / CLA_GROUP_W;
  localparam int NUNIT = WIDTH / CLA_UNIT_W;

  if (!cla_width_ok(WIDTH)) begin : g_bad_width
    $error("carry_look_ahead_adder_32bit: WIDTH must be 16 or 32");
  end

  logic [WIDTH-1:0] sum_d;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_c;
  logic [NUNIT:0]   unit_c;
  logic [NUNIT-1:0] blk_p;
  logic [NUNIT-1:0] blk_g;
  logic             unused_blk_pg;

  // Block P/G are exposed for a future third level; nothing consumes them yet.
  assign unused_blk_pg = ^{blk_p, blk_g};

  assign unit_c[0] = cin;

  // Second-level units; the only ripple hop is between 16-bit halves.
  for (genvar u = 0; u < NUNIT; u++) begin : g_unit
    assign grp_c[u*CLA_GROUPS_PER_LEVEL] = unit_c[u];

    cla_lookahead_unit u_lau (
      .p     (grp_p[u*CLA_GROUPS_PER_LEVEL +: CLA_GROUPS_PER_LEVEL]),
      .g     (grp_g[u*CLA_GROUPS_PER_LEVEL +: CLA_GROUPS_PER_LEVEL]),
      .cin   (unit_c[u]),
      .c     (grp_c[u*CLA_GROUPS_PER_LEVEL+1 +: 3]),
      .blk_p (blk_p[u]),
      .blk_g (blk_g[u]),
      .cout  (unit_c[u+1])
    );
  end

  // First-level 4-bit slices, each fed by its lookahead carry.
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla_4bit u_slice (
      .a   (A[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .b   (B[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin (grp_c[gi]),
      .s   (sum_d[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .p   (grp_p[gi]),
      .g   (grp_g[gi])
    );
  end

  // Output register; reset wins over any operand presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_d;
      cout <= unit_c[NUNIT];
    end
  end

endmodule

// File: tb/tb_carry_look_ahead_adder_32bit.sv
module tb_carry_look_ahead_adder_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16;
  logic [31:0] a32, b32, sum32;
  logic        cin32, cout32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  carry_look_ahead_adder_32bit #(.WIDTH(16)) dut16 (
    .clk (clk), .rst_n (rst_n), .A (a16), .B (b16), .cin (cin16),
    .sum (sum16), .cout (cout16)
  );

  carry_look_ahead_adder_32bit #(.WIDTH(32)) dut32 (
    .clk (clk), .rst_n (rst_n), .A (a32), .B (b32), .cin (cin32),
    .sum (sum32), .cout (cout32)
  );

  typedef struct {
    string       name;
    logic        r;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] e;
  } vec_t;

  vec_t tv[14];

  // Reference: integer addition, zero while reset is asserted.
  function automatic logic [16:0] ref16(input logic r, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    return r ? (17'(a) + 17'(b) + 17'(c)) : 17'd0;
  endfunction

  function automatic logic [32:0] ref32(input logic r, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    return r ? (33'(a) + 33'(b) + 33'(c)) : 33'd0;
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive both DUTs, take one edge, and compare 16-bit result with e16
  // and 32-bit result with the reference model.
  task automatic step(input string nm, input logic r,
                      input logic [15:0] x16, input logic [15:0] y16, input logic c16,
                      input logic [16:0] e16,
                      input logic [31:0] x32, input logic [31:0] y32, input logic c32);
    logic [32:0] e32;
    rst_n = r;
    a16 = x16; b16 = y16; cin16 = c16;
    a32 = x32; b32 = y32; cin32 = c32;
    e32 = ref32(r, x32, y32, c32);
    @(posedge clk);
    #1;
    chk({nm, "/w16"}, 33'({cout16, sum16}), 33'(e16));
    chk({nm, "/w32"}, {cout32, sum32}, e32);
  endtask

  initial begin
    tv[0]  = '{"reset0",    1'b0, 16'h1234, 16'h1111, 1'b0, 17'h00000};
    tv[1]  = '{"reset1",    1'b0, 16'h1234, 16'h1111, 1'b0, 17'h00000};
    tv[2]  = '{"post_rst",  1'b1, 16'h1234, 16'h1111, 1'b0, 17'h02345};
    tv[3]  = '{"1+0",       1'b1, 16'h0001, 16'h0000, 1'b0, 17'h00001};
    tv[4]  = '{"0+0",       1'b1, 16'h0000, 16'h0000, 1'b0, 17'h00000};
    tv[5]  = '{"0+1",       1'b1, 16'h0000, 16'h0001, 1'b0, 17'h00001};
    tv[6]  = '{"12+1",      1'b1, 16'd12,   16'd1,    1'b0, 17'd13};
    tv[7]  = '{"12+4",      1'b1, 16'd12,   16'd4,    1'b0, 17'd16};
    tv[8]  = '{"ffff+0+1",  1'b1, 16'hFFFF, 16'h0000, 1'b1, 17'h10000};
    tv[9]  = '{"ffff+ffff+1",1'b1,16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tv[10] = '{"000f+1",    1'b1, 16'h000F, 16'h0001, 1'b0, 17'h00010};
    tv[11] = '{"0fff+1",    1'b1, 16'h0FFF, 16'h0001, 1'b0, 17'h01000};
    tv[12] = '{"mid_rst",   1'b0, 16'h8000, 16'h8000, 1'b0, 17'h00000};
    tv[13] = '{"after_rst", 1'b1, 16'h8000, 16'h8000, 1'b0, 17'h10000};

    // Directed table on the 16-bit adder; the 32-bit adder sees random
    // operands alongside it so both share the same reset sequence.
    for (int i = 0; i < 14; i++) begin
      step(tv[i].name, tv[i].r, tv[i].a, tv[i].b, tv[i].ci, tv[i].e,
           $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // 32-bit corner cases: full carry chain and the hop between halves.
    step("w32_ffffffff+1", 1'b1, 16'h0, 16'h0, 1'b0, 17'h0,
         32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step("w32_half_hop", 1'b1, 16'h0, 16'h0, 1'b0, 17'h0,
         32'h0000_FFFF, 32'h0000_0001, 1'b0);
    step("w32_all_ones_cin", 1'b1, 16'h0, 16'h0, 1'b0, 17'h0,
         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back random operands on both widths.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] x, y;
      logic        c;
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      step("rand", 1'b1, x, y, c, ref16(1'b1, x, y, c),
           $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of random traffic, then resume.
    step("rand_rst", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h0,
         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step("rand_resume", 1'b1, 16'hABCD, 16'h5432, 1'b1, ref16(1'b1, 16'hABCD, 16'h5432, 1'b1),
         32'h8000_0000, 32'h8000_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/carry_look_ahead_adder_32bit.md
# carry_look_ahead_adder_32bit

Registered two-level carry-lookahead adder computing `sum = A + B + cin` with carry-out. It is built from 4-bit lookahead groups joined by a group-level lookahead unit. It serves as the datapath adder for the ECE465 arithmetic blocks. The default width is 16 bits; the WIDTH parameter allows 32.

## Interface
- `WIDTH`, default 16: operand/sum width. Legal values are 16 and 32; any other value is an elaboration error.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `A`, input, WIDTH: addend, unsigned.
- `B`, input, WIDTH: addend, unsigned.
- `cin`, input, 1: carry into bit 0.
- `sum`, output, WIDTH: registered `(A + B + cin) mod 2^WIDTH`.
- `cout`, output, 1: registered carry out of bit WIDTH-1.

## Operation
- Per-bit signals: `g[i] = A[i] & B[i]`, `p[i] = A[i] ^ B[i]`, `s[i] = p[i] ^ c[i]`, with `c[0] = cin`.
- 4-bit group internal carries use flattened lookahead equations, not a ripple chain:
  - `c1 = g0 | p0·c0`
  - `c2 = g1 | p1·g0 | p1·p0·c0`
  - `c3` follows the same pattern.
- Each 4-bit group emits a group propagate `P = p3·p2·p1·p0` and a group generate `G = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0`.
- A second-level lookahead unit takes four (P, G) pairs plus a carry-in. It produces the three inter-group carries and the block carry-out using the same equations.
- WIDTH=16: one second-level unit; its carry-out is `cout`.
- WIDTH=32: two second-level units. The first unit's carry-out feeds the second unit's carry-in (single ripple hop between 16-bit halves).
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is reported only through `cout`; there is no signed-overflow flag.
- The result `{cout, sum}` must equal the WIDTH+1-bit value `A + B + cin` for all inputs.

## Timing
- Combinational path from A/B/cin to the D-inputs of the `sum`/`cout` registers.
- Latency is 1 cycle: inputs stable before rising edge k appear on `sum`/`cout` after edge k.
- Throughput is one addition per cycle; there is no handshake or valid signal, and new operands are accepted every cycle.
- Reset: while `rst_n` = 0 at a rising edge, `sum` ← 0 and `cout` ← 0. Reset overrides any concurrent operand.
- Inputs present on the first edge with `rst_n` = 1 are added normally.
- Outputs hold their value between edges, and are undefined before the first reset edge.

## Structure
- Shared package `cla_pkg` holds:
  - `CLA_GROUP_W = 4`
  - `CLA_GROUPS_PER_LEVEL = 4`
  - the legal-width check constant
- Sub-module `cla_4bit`: 4-bit adder slice.
  - Inputs: a, b, cin.
  - Outputs: s[3:0], group P, group G.
- Sub-module `cla_lookahead_unit`: second-level unit.
  - Inputs: four P/G pairs and cin.
  - Outputs: c[3:1], block P, block G, cout.
- Top level: generate loop of `cla_4bit` instances, lookahead units, and the output register with reset.

## Test plan
- Apply reset for 2 cycles with A=0x1234, B=0x1111 → `sum`=0 and `cout`=0 throughout the reset cycles. After releasing `rst_n`, next edge → `sum`=0x2345, `cout`=0.
- Single bits, cin=0, one test per cycle, result 1 cycle after each input:
  - A=1, B=0 → `sum`=1.
  - A=0, B=0 → `sum`=0.
  - A=0, B=1 → `sum`=1.
  - A=12, B=1 → `sum`=13.
  - A=12, B=4 → `sum`=16.
  - All cases: `cout`=0.
- Full carry chain: A=0xFFFF, B=0x0000, cin=1 → `sum`=0x0000, `cout`=1. Also A=0xFFFF, B=0xFFFF, cin=1 → `sum`=0xFFFF, `cout`=1.
- Group boundaries: A=0x000F, B=0x0001, cin=0 → `sum`=0x0010. Also A=0x0FFF, B=0x0001 → `sum`=0x1000. Both with `cout`=0.
- Back-to-back operands changing every cycle: 1000 random (A, B, cin) triples compared against a reference `A + B + cin` delayed by one cycle → zero mismatches. Repeat with WIDTH=32, including A=0xFFFFFFFF, B=1 → `sum`=0, `cout`=1.
- Reset mid-stream: assert `rst_n`=0 for one edge while A=0x8000, B=0x8000 → outputs 0 and `cout`=0 on that edge. Following edge with `rst_n`=1 → `sum`=0x0000, `cout`=1.
